// File: rtl/blink_pkg.sv
// Shared types and default sizing for the blink scheduler.
// No logic here; used by blink_sched and rr_arb.
package blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int DEF_HALF  = 50000000;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_NBITS = 4;

endpackage

// File: rtl/blink_sched_rr_arb.sv
// Round-robin picker: first set req bit searching upward from rr_ptr+1, wrapping.
// Latency: combinational. Backpressure: none; an all-zero req gives an all-zero select.
module rr_arb
  import blink_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] sel_oh,
  output logic [IW-1:0]   sel_idx
);

  logic found;
  int   idx;

  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        sel_oh[idx] = 1'b1;
        sel_idx     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/blink_sched.sv
// Grants one requester at a time and blinks the LED its latched count of times, then a dark gap.
// Latency: grant one cycle after req; backpressure: the grantee holds req high, dropping it aborts.
module blink_sched
  import blink_pkg::*;
#(
  parameter int HALF  = DEF_HALF,
  parameter int NREQ  = DEF_NREQ,
  parameter int NBITS = DEF_NBITS,
  parameter int CBITS = $clog2(HALF),
  parameter int IW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NBITS-1:0] cnt,
  output logic [NREQ-1:0]       gnt,
  output logic [IW-1:0]         owner,
  output logic                  busy,
  output logic                  led,
  output logic                  flg,
  output logic                  done
);

  localparam logic [CBITS-1:0] HALF_M1 = CBITS'(HALF - 1);

  state_t            st, st_n;
  logic [IW-1:0]     rr_ptr, rr_n, owner_n;
  logic [NREQ-1:0]   gnt_n, sel_oh;
  logic [IW-1:0]     sel_idx;
  logic [CBITS-1:0]  psc, psc_n;
  logic [NBITS-1:0]  rem, rem_n, sel_cnt;
  logic              led_n, flg_n, done_n, expire, abort;

  rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .sel_oh  (sel_oh),
    .sel_idx (sel_idx)
  );

  assign sel_cnt = cnt[int'(sel_idx)*NBITS +: NBITS];
  assign busy    = (st != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= ST_IDLE;
      gnt    <= '0;
      owner  <= '0;
      rr_ptr <= IW'(NREQ - 1);
      psc    <= '0;
      rem    <= '0;
      led    <= 1'b0;
      flg    <= 1'b0;
      done   <= 1'b0;
    end else begin
      st     <= st_n;
      gnt    <= gnt_n;
      owner  <= owner_n;
      rr_ptr <= rr_n;
      psc    <= psc_n;
      rem    <= rem_n;
      led    <= led_n;
      flg    <= flg_n;
      done   <= done_n;
    end
  end

  always_comb begin
    st_n    = st;
    gnt_n   = gnt;
    owner_n = owner;
    rr_n    = rr_ptr;
    psc_n   = psc;
    rem_n   = rem;
    led_n   = led;
    done_n  = 1'b0;
    expire  = (psc == HALF_M1);
    abort   = !req[owner];

    if (st == ST_IDLE) begin
      gnt_n = '0;
      led_n = 1'b0;
      psc_n = '0;
      if (|req) begin
        gnt_n   = sel_oh;
        owner_n = sel_idx;
        rr_n    = sel_idx;
        rem_n   = sel_cnt;
        if (sel_cnt != '0) begin
          st_n  = ST_ON;
          led_n = 1'b1;
        end else begin
          st_n  = ST_GAP;
        end
      end
    end else if (abort) begin
      // Grantee withdrew: drop straight to idle, pointer stays on it.
      st_n  = ST_IDLE;
      gnt_n = '0;
      led_n = 1'b0;
      psc_n = '0;
    end else if (!expire) begin
      psc_n = psc + CBITS'(1);
    end else begin
      psc_n = '0;
      unique case (st)
        ST_ON: begin
          st_n  = ST_OFF;
          led_n = 1'b0;
        end
        ST_OFF: begin
          rem_n = rem - NBITS'(1);
          if (rem_n != '0) begin
            st_n  = ST_ON;
            led_n = 1'b1;
          end else begin
            st_n  = ST_GAP;
            led_n = 1'b0;
          end
        end
        default: begin
          st_n   = ST_IDLE;
          gnt_n  = '0;
          led_n  = 1'b0;
          done_n = 1'b1;
        end
      endcase
    end

    // flg is registered, so predict the cycle in which the prescaler will sit at HALF-1.
    flg_n = (st_n != ST_IDLE) && (psc_n == HALF_M1);
  end

endmodule
